// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder. The cin signal exists only
// when SERIAL_ADDER_CIN_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  // Both channels use valid/ready: a transfer happens on a rising clk edge
  // where valid && ready. The producer holds valid until that edge.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_CIN_EN
  logic             cin;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport slave (
    input  in_valid, a, b,
`ifdef SERIAL_ADDER_CIN_EN
    input  cin,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, carry_out
  );

  modport master (
    output in_valid, a, b,
`ifdef SERIAL_ADDER_CIN_EN
    output cin,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, carry_out
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: two half-adder cells plus a carry register, LSB first.
// Define SERIAL_ADDER_CIN_EN to add a carry-in sampled on the accept edge.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_if.slave        bus,
  output logic [1:0]           state_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             carry_out_q;
  logic [CW-1:0]    cnt_q;

  logic ha1_s, ha1_c, ha2_s, ha2_c;
  logic carry_d;
  logic carry_init;

  always_comb begin
    ha1_s   = a_sh_q[0] ^ b_sh_q[0];
    ha1_c   = a_sh_q[0] & b_sh_q[0];
    ha2_s   = ha1_s ^ carry_q;
    ha2_c   = ha1_s & carry_q;
    carry_d = ha1_c | ha2_c;
  end

`ifdef SERIAL_ADDER_CIN_EN
  assign carry_init = bus.cin;
`else
  assign carry_init = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            carry_q <= carry_init;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // Each sum bit enters at the MSB so bit 0 ends up in sum_q[0].
          sum_q   <= {ha2_s, sum_q[WIDTH-1:1]};
          a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
          carry_q <= carry_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            carry_out_q <= carry_d;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): table of operand vectors plus
// hand-written backpressure and mid-operation reset sequences.
module tb_serial_adder;
  localparam int W = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_o;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_co;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge
  // with the DUT idle again, so calls can be chained back-to-back.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] exp_sum, input logic exp_co,
                        input int hold);
    int lat;
    check({name, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
`ifdef SERIAL_ADDER_CIN_EN
    bus.cin       = cin;
`endif
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
`ifdef SERIAL_ADDER_CIN_EN
    bus.cin      = ~cin;
`endif
    lat = 0;
    while (!bus.out_valid && lat < 4 * W) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(W));
    check({name, " sum"}, 32'(bus.sum), 32'(exp_sum));
    check({name, " carry_out"}, 32'(bus.carry_out), 32'(exp_co));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      @(negedge clk);
      check({name, " held out_valid"}, 32'(bus.out_valid), 32'd1);
      check({name, " held in_ready"}, 32'(bus.in_ready), 32'd0);
      check({name, " held sum"}, 32'(bus.sum), 32'(exp_sum));
      check({name, " held carry_out"}, 32'(bus.carry_out), 32'(exp_co));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, " out_valid after handoff"}, 32'(bus.out_valid), 32'd0);
    check({name, " in_ready after handoff"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
    vecs.push_back('{8'h01, 8'h01, 1'b0, 8'h02, 1'b0});
    vecs.push_back('{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{8'h96, 8'h6B, 1'b0, 8'h01, 1'b1});
`ifdef SERIAL_ADDER_CIN_EN
    vecs.push_back('{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1});
    vecs.push_back('{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1});
    vecs.push_back('{8'h12, 8'h34, 1'b1, 8'h47, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 8'h01, 1'b0});
`endif

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
`ifdef SERIAL_ADDER_CIN_EN
    bus.cin       = 1'b0;
`endif
    bus.out_ready = 1'b0;
    #1;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset sum", 32'(bus.sum), 32'd0);
    check("reset carry_out", 32'(bus.carry_out), 32'd0);
    check("reset state", 32'(state_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", 32'(bus.in_ready), 32'd1);

    // back-to-back table vectors
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].exp_sum, vecs[i].exp_co, 0);

    // backpressure in DONE with ignored in_valid pulses
    run_op("backpressure", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 5);

    // reset after three shift edges
    bus.in_valid = 1'b1;
    bus.a        = 8'hC3;
    bus.b        = 8'h77;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop reset out_valid", 32'(bus.out_valid), 32'd0);
    check("midop reset sum", 32'(bus.sum), 32'd0);
    check("midop reset carry_out", 32'(bus.carry_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("no out_valid after abort", 32'(seen), 32'd0);
    run_op("after reset", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
